// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: screen geometry, coordinate width and the
// ball engine state encoding.
package breakout_pkg;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned COORD_W = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMove = 2'd1,
        StMiss = 2'd2
    } ball_state_e;

endpackage

// File: rtl/axis_step.sv
// Per-axis position/direction update with reflection off two walls:
// 0 at the low end and HI_LIMIT at the high end.
// Ports:
//   pos_i     current position
//   dir_i     current direction (1 = increasing, 0 = decreasing)
//   en_i      step enable; when low, outputs equal inputs
//   pos_o     next position
//   dir_o     next direction
//   reflect_o a wall was hit on this step
module axis_step #(
    parameter int unsigned STEP     = 2,
    parameter int unsigned HI_LIMIT = 632
) (
    input  logic [breakout_pkg::COORD_W-1:0] pos_i,
    input  logic                             dir_i,
    input  logic                             en_i,
    output logic [breakout_pkg::COORD_W-1:0] pos_o,
    output logic                             dir_o,
    output logic                             reflect_o
);
    import breakout_pkg::*;

    localparam logic [COORD_W:0] StepW = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0] HiW   = (COORD_W + 1)'(HI_LIMIT);

    // One extra bit so the sum can never wrap.
    logic [COORD_W:0] pos_ext;
    logic [COORD_W:0] pos_inc;

    assign pos_ext = {1'b0, pos_i};
    assign pos_inc = pos_ext + StepW;

    always_comb begin
        pos_o     = pos_i;
        dir_o     = dir_i;
        reflect_o = 1'b0;
        if (en_i) begin
            if (dir_i) begin
                if (pos_inc >= HiW) begin
                    pos_o     = HiW[COORD_W-1:0];
                    dir_o     = 1'b0;
                    reflect_o = 1'b1;
                end else begin
                    pos_o = pos_inc[COORD_W-1:0];
                end
            end else begin
                if (pos_ext <= StepW) begin
                    pos_o     = '0;
                    dir_o     = 1'b1;
                    reflect_o = 1'b1;
                end else begin
                    pos_o = pos_i - StepW[COORD_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Tick-driven ball position engine for the Breakout playfield.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   tick_i      one-cycle frame refresh strobe
//   launch_i    start request (level or pulse), honoured only when idle
//   paddle_x_i  paddle left edge, sampled on tick
//   ball_x_o    ball left edge
//   ball_y_o    ball top edge
//   moving_o    ball in flight
//   bounce_o    one-cycle pulse on any reflection
//   miss_o      one-cycle pulse when the ball leaves past the bottom
module ball_motion #(
    parameter int unsigned H_RES     = breakout_pkg::H_RES,
    parameter int unsigned V_RES     = breakout_pkg::V_RES,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned STEP      = 2,
    parameter int unsigned PADDLE_W  = 64,
    parameter int unsigned PADDLE_Y  = 440,
    parameter int unsigned START_X   = 316,
    parameter int unsigned START_Y   = 300
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             tick_i,
    input  logic                             launch_i,
    input  logic [breakout_pkg::COORD_W-1:0] paddle_x_i,
    output logic [breakout_pkg::COORD_W-1:0] ball_x_o,
    output logic [breakout_pkg::COORD_W-1:0] ball_y_o,
    output logic                             moving_o,
    output logic                             bounce_o,
    output logic                             miss_o
);
    import breakout_pkg::*;

    localparam logic [COORD_W-1:0] StartX   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] StartY   = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] PaddleTop = COORD_W'(PADDLE_Y - BALL_SIZE);
    localparam logic [COORD_W:0]   SizeW    = (COORD_W + 1)'(BALL_SIZE);
    localparam logic [COORD_W:0]   StepW    = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0]   PadYW    = (COORD_W + 1)'(PADDLE_Y);
    localparam logic [COORD_W:0]   PadWW    = (COORD_W + 1)'(PADDLE_W);
    localparam logic [COORD_W:0]   FloorW   = (COORD_W + 1)'(V_RES - BALL_SIZE);

    ball_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d; // 1 = right / down
    logic               bounce_q, bounce_d;

    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               dx_nxt, dy_nxt, x_refl, y_refl;

    axis_step #(
        .STEP     (STEP),
        .HI_LIMIT (H_RES - BALL_SIZE)
    ) u_x_step (
        .pos_i     (x_q),
        .dir_i     (dx_q),
        .en_i      (tick_i),
        .pos_o     (x_nxt),
        .dir_o     (dx_nxt),
        .reflect_o (x_refl)
    );

    // Only the upward (top wall) half of this instance is used; the
    // downward direction is handled by paddle/floor logic below.
    axis_step #(
        .STEP     (STEP),
        .HI_LIMIT (V_RES - BALL_SIZE)
    ) u_y_step (
        .pos_i     (y_q),
        .dir_i     (dy_q),
        .en_i      (tick_i),
        .pos_o     (y_nxt),
        .dir_o     (dy_nxt),
        .reflect_o (y_refl)
    );

    logic [COORD_W:0] x_ext, y_ext, px_ext, y_bot;
    logic             paddle_hit, floor_hit;

    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};
    assign px_ext = {1'b0, paddle_x_i};
    assign y_bot  = y_ext + SizeW;

    // Paddle uses the pre-update x and wins over the floor test.
    assign paddle_hit = dy_q && (y_bot <= PadYW) && (y_bot + StepW >= PadYW) &&
                        (x_ext + SizeW > px_ext) && (x_ext < px_ext + PadWW);
    assign floor_hit  = dy_q && (y_ext + StepW >= FloorW);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        bounce_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A tick arriving with launch only starts flight, no step.
                if (launch_i) begin
                    state_d = StMove;
                    dx_d    = 1'b1;
                    dy_d    = 1'b0;
                end
            end
            StMove: begin
                if (tick_i) begin
                    if (floor_hit && !paddle_hit) begin
                        state_d = StMiss;
                    end else begin
                        x_d  = x_nxt;
                        dx_d = dx_nxt;
                        if (paddle_hit) begin
                            y_d  = PaddleTop;
                            dy_d = 1'b0;
                        end else if (dy_q) begin
                            y_d = y_q + StepW[COORD_W-1:0];
                        end else begin
                            y_d  = y_nxt;
                            dy_d = dy_nxt;
                        end
                        // Corner hits still give a single pulse.
                        bounce_d = x_refl | paddle_hit | (~dy_q & y_refl);
                    end
                end
            end
            StMiss: begin
                state_d = StIdle;
                x_d     = StartX;
                y_d     = StartY;
                dx_d    = 1'b1;
                dy_d    = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            x_q      <= StartX;
            y_q      <= StartY;
            dx_q     <= 1'b1;
            dy_q     <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            bounce_q <= bounce_d;
        end
    end

    assign ball_x_o = x_q;
    assign ball_y_o = y_q;
    assign bounce_o = bounce_q;
    assign moving_o = (state_q == StMove);
    assign miss_o   = (state_q == StMiss);

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

    localparam int HMAX0 = 632; // 640 - 8
    localparam int HMAX1 = 616; // 624 - 8, places a right/top corner at tick 150

    typedef struct {
        int mode; // 0 idle, 1 move, 2 miss
        int x;
        int y;
        int dx;
        int dy;
        bit b;
    } mdl_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tick_i = 1'b0;
    logic       launch_i = 1'b0;
    logic [9:0] paddle_x_i = '0;

    logic [9:0] x0, y0, x1, y1;
    logic       mv0, bn0, ms0, mv1, bn1, ms1;

    int checks = 0;
    int errors = 0;

    mdl_t m0, m1;

    always #5 clk_i = ~clk_i;

    ball_motion u_dut0 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tick_i     (tick_i),
        .launch_i   (launch_i),
        .paddle_x_i (paddle_x_i),
        .ball_x_o   (x0),
        .ball_y_o   (y0),
        .moving_o   (mv0),
        .bounce_o   (bn0),
        .miss_o     (ms0)
    );

    ball_motion #(.H_RES(624)) u_dut1 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tick_i     (tick_i),
        .launch_i   (launch_i),
        .paddle_x_i (paddle_x_i),
        .ball_x_o   (x1),
        .ball_y_o   (y1),
        .moving_o   (mv1),
        .bounce_o   (bn1),
        .miss_o     (ms1)
    );

    function automatic mdl_t parked();
        mdl_t p;
        p.mode = 0; p.x = 316; p.y = 300; p.dx = 1; p.dy = -1; p.b = 1'b0;
        return p;
    endfunction

    // Game rules in plain signed arithmetic.
    function automatic mdl_t step_model(mdl_t m, int hmax, bit tk, bit ln, int px);
        mdl_t n;
        bit   hit;
        n   = m;
        n.b = 1'b0;
        hit = (m.dy > 0) && (m.y + 8 <= 440) && (m.y + 10 >= 440) &&
              (m.x + 8 > px) && (m.x < px + 64);
        if (m.mode == 2) begin
            n = parked();
        end else if (m.mode == 0) begin
            if (ln) begin
                n.mode = 1; n.dx = 1; n.dy = -1;
            end
        end else if (tk) begin
            if (m.dy > 0 && !hit && m.y + 2 >= 472) begin
                n.mode = 2;
            end else begin
                n.x = m.x + 2 * m.dx;
                if (n.x >= hmax) begin
                    n.x = hmax; n.dx = -1; n.b = 1'b1;
                end else if (n.x <= 0) begin
                    n.x = 0; n.dx = 1; n.b = 1'b1;
                end
                if (hit) begin
                    n.y = 432; n.dy = -1; n.b = 1'b1;
                end else begin
                    n.y = m.y + 2 * m.dy;
                    if (n.y <= 0) begin
                        n.y = 0; n.dy = 1; n.b = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m0 <= parked();
            m1 <= parked();
        end else begin
            m0 <= step_model(m0, HMAX0, tick_i, launch_i, int'(paddle_x_i));
            m1 <= step_model(m1, HMAX1, tick_i, launch_i, int'(paddle_x_i));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t m, input logic [9:0] x,
                            input logic [9:0] y, input logic mv, input logic bn,
                            input logic ms);
        chk({tag, ".x"}, int'(x), m.x);
        chk({tag, ".y"}, int'(y), m.y);
        chk({tag, ".moving"}, int'(mv), int'(m.mode == 1));
        chk({tag, ".bounce"}, int'(bn), int'(m.b));
        chk({tag, ".miss"}, int'(ms), int'(m.mode == 2));
    endtask

    always @(negedge clk_i) begin
        cmp_inst("dut0", m0, x0, y0, mv0, bn0, ms0);
        cmp_inst("dut1", m1, x1, y1, mv1, bn1, ms1);
    end

    // Called at a negedge; returns at the negedge one cycle after the tick
    // edge so its results can be checked, with tick already low again.
    bit follow_paddle = 1'b1;

    task automatic do_tick();
        int px;
        if (follow_paddle) begin
            px = (m0.x >= 28) ? m0.x - 28 : 0;
        end else begin
            px = (m0.x < 320) ? 576 : 0;
        end
        paddle_x_i = 10'(px);
        tick_i = 1'b1;
        @(negedge clk_i);
        tick_i = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk_i);
    endtask

    initial begin
        int  t;
        bit  missed;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.x", int'(x0), 316);
        chk("rst.y", int'(y0), 300);
        chk("rst.moving", int'(mv0), 0);
        rst_ni = 1'b1;
        gap();

        for (int i = 0; i < 5; i++) begin
            do_tick();
            gap();
        end
        chk("idle_ticks.x", int'(x0), 316);
        chk("idle_ticks.y", int'(y0), 300);

        launch_i = 1'b1;
        @(negedge clk_i);
        launch_i = 1'b0;
        chk("launch.moving", int'(mv0), 1);
        gap();

        missed = 1'b0;
        t = 0;
        while (t < 2000 && !missed) begin
            do_tick();
            t++;
            if (t == 10) begin
                chk("t10.x", int'(x0), 336);
                chk("t10.y", int'(y0), 280);
                chk("t10.bounce", int'(bn0), 0);
            end
            if (t == 150) begin
                chk("t150.dut0.y", int'(y0), 0);
                chk("t150.dut0.bounce", int'(bn0), 1);
                chk("t150.corner.x", int'(x1), 616);
                chk("t150.corner.y", int'(y1), 0);
                chk("t150.corner.bounce", int'(bn1), 1);
            end
            if (t == 151) begin
                chk("t151.corner.x", int'(x1), 614);
                chk("t151.corner.y", int'(y1), 2);
                chk("t151.corner.bounce", int'(bn1), 0);
            end
            if (t == 158) begin
                chk("t158.x", int'(x0), 632);
                chk("t158.bounce", int'(bn0), 1);
            end
            if (t == 366) begin
                chk("paddle.y", int'(y0), 432);
                chk("paddle.x", int'(x0), 216);
                chk("paddle.bounce", int'(bn0), 1);
                follow_paddle = 1'b0;
            end
            if (m0.mode == 2) missed = 1'b1;
            gap();
        end
        chk("miss.seen", int'(missed), 1);
        chk("miss.tick", t, 818);

        // Miss pulse was checked by the compare process; parked now.
        chk("park.x", int'(x0), 316);
        chk("park.y", int'(y0), 300);
        chk("park.moving", int'(mv0), 0);
        chk("park.miss", int'(ms0), 0);

        launch_i = 1'b1;
        @(negedge clk_i);
        launch_i = 1'b0;
        gap();
        for (int i = 0; i < 20; i++) begin
            do_tick();
            gap();
        end
        chk("flight.x", int'(x0), 356);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst.x", int'(x0), 316);
        chk("async_rst.y", int'(y0), 300);
        chk("async_rst.moving", int'(mv0), 0);
        chk("async_rst.miss", int'(ms0), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        gap();

        launch_i = 1'b1;
        tick_i   = 1'b1;
        @(negedge clk_i);
        launch_i = 1'b0;
        tick_i   = 1'b0;
        chk("launch_tick.moving", int'(mv0), 1);
        chk("launch_tick.x", int'(x0), 316);
        chk("launch_tick.y", int'(y0), 300);
        gap();
        do_tick();
        chk("first_step.x", int'(x0), 318);
        chk("first_step.y", int'(y0), 298);
        gap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Tick-driven ball position engine for the Breakout playfield. It consumes the single-cycle frame-refresh tick from the refresh tick generator and advances the ball by a fixed step on each tick. The ball reflects off the left, right and top walls and off the paddle; a miss past the bottom edge is reported. Outputs feed the pixel renderer and the game/score logic.

## Interface
- `H_RES`, 640: active horizontal pixels
- `V_RES`, 480: active vertical lines
- `BALL_SIZE`, 8: ball edge length in pixels (square)
- `STEP`, 2: pixels moved per tick on each axis, 1..BALL_SIZE
- `PADDLE_W`, 64: paddle width in pixels
- `PADDLE_Y`, 440: top row of the paddle
- `START_X`, 316: ball parked x (left edge)
- `START_Y`, 300: ball parked y (top edge)

Ports:
- `clk`  in  1  system clock (125 MHz)
- `reset`  in  1  asynchronous, active-low reset
- `tick`  in  1  one-cycle refresh strobe (75 Hz)
- `launch`  in  1  start request, level or pulse
- `paddle_x`  in  10  paddle left edge, sampled on tick
- `ball_x`  out  10  ball left edge
- `ball_y`  out  10  ball top edge
- `moving`  out  1  high in MOVE state
- `bounce`  out  1  one-cycle pulse on any reflection
- `miss`  out  1  one-cycle pulse when ball exits bottom

## Operation
- Three states: IDLE, MOVE, MISS. Encoding lives in the shared package.
- Reset values:
  - state = IDLE
  - `ball_x` = START_X, `ball_y` = START_Y
  - dx = +, dy = − (up)
  - `moving` = 0, `bounce` = 0, `miss` = 0
- IDLE:
  - Ball is parked at (START_X, START_Y) and ticks are ignored.
  - `launch`=1 moves to MOVE with dx=+ and dy=−.
  - If tick and launch arrive in the same cycle: transition only, no position step.
- MOVE: on each tick, x and y update independently using 11-bit unsigned intermediates (no wrap).
  - x, dx=+: if x+STEP ≥ H_RES−BALL_SIZE then x=H_RES−BALL_SIZE, dx=−, reflect; else x+=STEP.
  - x, dx=−: if x ≤ STEP then x=0, dx=+, reflect; else x−=STEP.
  - y, dy=−: if y ≤ STEP then y=0, dy=+, reflect; else y−=STEP.
  - Paddle hit: dy=+, y+BALL_SIZE ≤ PADDLE_Y, y+STEP+BALL_SIZE ≥ PADDLE_Y, ball_x+BALL_SIZE > paddle_x, and ball_x < paddle_x+PADDLE_W. Result: y=PADDLE_Y−BALL_SIZE, dy=−, reflect.
  - Otherwise with dy=+: if y+STEP ≥ V_RES−BALL_SIZE then go to MISS and hold position; else y+=STEP.
  - The paddle test uses pre-update ball_x. Paddle test takes priority over the miss test.
  - Corner case: reflections on both axes in one tick produce a single `bounce` pulse.
  - `launch` is ignored in MOVE. Cycles without a tick leave all state unchanged.
- MISS: lasts exactly one cycle with `miss`=1, then IDLE. Position restores to START, dx=+, dy=−.
- Reset asserted mid-operation returns immediately to reset values; no `miss` is emitted.

## Timing
- `tick` seen at cycle n: updated `ball_x`/`ball_y`/`bounce` visible at n+1. All outputs are registered.
- `bounce` is high for exactly cycle n+1.
- `miss` is high the cycle after the bottom-exit tick. Parked position is visible one cycle later.
- `launch` at cycle n: `moving`=1 at n+1. The first step occurs on the next tick after n.
- `tick` is assumed to be no more frequent than every 2 cycles. Back-to-back ticks must still each step in MOVE.
- Reset deassertion is synchronised externally; release takes effect on the next clk edge.

## Structure
- Shared package `breakout_pkg`:
  - state enum {IDLE, MOVE, MISS}
  - screen constants H_RES/V_RES
  - coordinate width (10)
- One sub-module, `axis_step`: a per-axis position/direction update with wall reflection (inputs pos, dir, enable; outputs next pos, next dir, reflect). Instantiate it for x and for the y top wall. Paddle and bottom logic stay in `ball_motion`.

## Test plan
- Reset low, then release. Expect (316,300), moving=0. Send 5 ticks: position unchanged. Pulse launch: moving=1 next cycle.
- Launch, then 10 ticks. Expect ball_x=336, ball_y=280, no bounce.
- Start at x=630, dx=+, tick: x=632, dx becomes −, bounce for 1 cycle. Next tick: x=630.
- y=431, dy=+, paddle_x=300, ball_x=320, tick: y=432, dy=−, bounce=1. Repeat with paddle_x=0 until y reaches 470 on a tick: miss=1 for one cycle, then (316,300) in IDLE.
- Corner: x=1, y=1, dx=−, dy=−, tick: (0,0), both directions flip, a single bounce pulse.
- Assert reset in MOVE mid-flight: outputs return to reset values asynchronously, miss stays 0. A launch in the same cycle as a tick in IDLE: no step.
